// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder and the core-side request port.
// Field widths here match the default 32-bit configuration.
package mem_responder_pkg;

    localparam int                  XLEN_DEF   = 32;
    localparam int                  MASK_W_DEF = XLEN_DEF / 8;
    localparam logic [XLEN_DEF-1:0] BASE_DEF   = 32'h8000_0000;
    localparam int                  CNT_W      = 5;
    localparam logic [7:0]          LFSR_SEED  = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN_DEF-1:0]   addr;
        logic                  wen;
        logic [XLEN_DEF-1:0]   wdata;
        logic [MASK_W_DEF-1:0] mask;
    } req_t;

    typedef struct packed {
        logic [XLEN_DEF-1:0] rdata;
        logic                err;
    } rsp_t;

endpackage

// File: rtl/mem_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that steps only when enabled.
// Only the two low bits leave the block; they select the extra wait cycles.
module mem_lfsr8
    import mem_responder_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       i_en,
    output logic [1:0] o_rand
);

    logic [7:0] r_lfsr;
    logic       w_fb;

    assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lfsr <= LFSR_SEED;
        end else if (i_en) begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
        end
    end

    assign o_rand = r_lfsr[1:0];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: valid/ready request in, programmable wait,
// word-addressed SRAM access, then a held valid/ready response.
//
// state | meaning
// IDLE  | ready for a request (req_ready_o=1)
// WAIT  | counting down the access latency; access happens when the count is zero
// RESP  | response registered; rsp_valid_o rises one cycle in, held until accepted
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int              XLEN       = XLEN_DEF,
    parameter int              DEPTH_LOG2 = 12,
    parameter logic [XLEN-1:0] BASE       = XLEN'(BASE_DEF),
    parameter int              LAT        = 2,
    parameter int              RAND_LAT   = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [XLEN-1:0]   req_addr_i,
    input  logic              req_wen_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    input  logic [XLEN/8-1:0] req_mask_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [XLEN-1:0]   rsp_rdata_o,
    output logic              rsp_err_o
);

    localparam int MASK_W = XLEN / 8;
    localparam int WORDS  = 1 << DEPTH_LOG2;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_addr;
    logic              r_wen;
    logic [XLEN-1:0]   r_wdata;
    logic [MASK_W-1:0] r_mask;
    logic [XLEN-1:0]   r_rdata;
    logic              r_err;
    logic              r_rsp_valid;
    logic [XLEN-1:0]   r_mem [0:WORDS-1];

    logic [XLEN:0]           w_diff;
    logic                    w_in_range;
    logic [DEPTH_LOG2-1:0]   w_idx;
    logic [1:0]              w_rand;
    logic                    w_accept;
    logic                    w_access;
    logic                    w_rsp_hs;
    logic                    w_req_ready;
    logic                    w_unused_lsb;

    // Extra top bit of the subtraction is the borrow: any address below BASE is out of range.
    assign w_diff       = {1'b0, r_addr} - {1'b0, BASE};
    assign w_in_range   = !w_diff[XLEN] && (w_diff[XLEN-1:DEPTH_LOG2+2] == '0);
    assign w_idx        = w_diff[DEPTH_LOG2+1:2];
    assign w_unused_lsb = ^w_diff[1:0];

    generate
        if (RAND_LAT != 0) begin : g_rand
            mem_lfsr8 u_lfsr (
                .clk_i  (clk_i),
                .rst_i  (rst_i),
                .i_en   (w_accept),
                .o_rand (w_rand)
            );
        end else begin : g_fixed
            assign w_rand = 2'b00;
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 1'b0;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        w_rsp_hs    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_access    = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (r_rsp_valid && rsp_ready_i) begin
                    w_rsp_hs    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wen       <= 1'b0;
            r_wdata     <= '0;
            r_mask      <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr  <= req_addr_i;
                r_wen   <= req_wen_i;
                r_wdata <= req_wdata_i;
                r_mask  <= req_mask_i;
                r_cnt   <= CNT_W'(LAT) + CNT_W'(w_rand);
            end else if (r_state == ST_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_access) begin
                r_rdata <= (w_in_range && !r_wen) ? r_mem[w_idx] : '0;
                r_err   <= !w_in_range;
            end
            // Valid trails entry into RESP by one cycle, giving LAT+2 edges from accept.
            if (r_state == ST_RESP && !r_rsp_valid) begin
                r_rsp_valid <= 1'b1;
            end else if (w_rsp_hs) begin
                r_rsp_valid <= 1'b0;
                r_err       <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_access && r_wen && w_in_range) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (r_mask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    assign req_ready_o = w_req_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rdata;
    assign rsp_err_o   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: instance 0 uses a fixed latency of 2, instance 1 uses LAT=1 with
// LFSR-driven extra wait and a 16-word array checked against a scoreboard.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_addr  [2];
    logic        req_wen   [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_mask  [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_responder #(.LAT(2), .RAND_LAT(0)) u_fix (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_addr_i(req_addr[0]), .req_wen_i(req_wen[0]),
        .req_wdata_i(req_wdata[0]), .req_mask_i(req_mask[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
        .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
    );

    mem_responder #(.DEPTH_LOG2(4), .LAT(1), .RAND_LAT(1)) u_rnd (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_addr_i(req_addr[1]), .req_wen_i(req_wen[1]),
        .req_wdata_i(req_wdata[1]), .req_mask_i(req_mask[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
        .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request, wait for its accept, then count edges until rsp_valid is seen.
    task automatic issue(input int s, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] m, output int edges);
        req_addr[s]  = a;
        req_wen[s]   = w;
        req_wdata[s] = d;
        req_mask[s]  = m;
        req_valid[s] = 1'b1;
        edges = 0;
        while (req_ready[s] !== 1'b1 && edges < 40) begin
            @(posedge clk); #1; edges++;
        end
        chk("req_ready_before_accept", {31'b0, req_ready[s]}, 32'd1);
        @(posedge clk); #1;
        req_valid[s] = 1'b0;
        edges = 0;
        while (rsp_valid[s] !== 1'b1 && edges < 40) begin
            @(posedge clk); #1; edges++;
        end
        chk("rsp_valid_seen", {31'b0, rsp_valid[s]}, 32'd1);
    endtask

    task automatic complete(input int s);
        rsp_ready[s] = 1'b1;
        @(posedge clk); #1;
        chk("rsp_valid_cleared", {31'b0, rsp_valid[s]}, 32'd0);
        chk("req_ready_after_hs", {31'b0, req_ready[s]}, 32'd1);
    endtask

    task automatic txn(input int s, input string tag, input logic [31:0] a, input logic w,
                       input logic [31:0] d, input logic [3:0] m,
                       input logic [31:0] exp_d, input logic exp_e, input int exp_lat);
        int lat;
        issue(s, a, w, d, m, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, rsp_rdata[s], exp_d);
        chk({tag, "_err"}, {31'b0, rsp_err[s]}, {31'b0, exp_e});
        complete(s);
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    initial begin
        int          lat;
        int          idx;
        logic [7:0]  lfsr_m;
        logic [31:0] sb [16];

        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0; req_addr[s] = '0; req_wen[s] = 1'b0;
            req_wdata[s] = '0;   req_mask[s] = '0; rsp_ready[s] = 1'b1;
        end
        #3;
        chk("rst_req_ready", {31'b0, req_ready[0]}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid[0]}, 32'd0);
        chk("rst_rdata", rsp_rdata[0], 32'd0);
        chk("rst_err", {31'b0, rsp_err[0]}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        txn(0, "preload", 32'h8000_0000, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 4);
        txn(0, "rd_base", 32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 4);
        txn(0, "rd_below", 32'h7FFF_FFFC, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 4);
        txn(0, "wr_old", 32'h8000_0010, 1'b1, 32'hAAAA_AAAA, 4'hF, 32'h0, 1'b0, 4);
        txn(0, "wr_mask5", 32'h8000_0010, 1'b1, 32'h1122_3344, 4'b0101, 32'h0, 1'b0, 4);
        txn(0, "rd_mask5", 32'h8000_0013, 1'b0, 32'h0, 4'h0, 32'hAA22_AA44, 1'b0, 4);
        txn(0, "rd_top", 32'h8000_4000, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 4);
        txn(0, "wr_last", 32'h8000_3FFC, 1'b1, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 4);
        txn(0, "wr_below", 32'h7FFF_FFFC, 1'b1, 32'h5555_5555, 4'hF, 32'h0, 1'b1, 4);
        txn(0, "wr_top", 32'h8000_4000, 1'b1, 32'h1234_5678, 4'hF, 32'h0, 1'b1, 4);
        txn(0, "wr_mask0", 32'h8000_0010, 1'b1, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, 4);
        txn(0, "rd_last", 32'h8000_3FFC, 1'b0, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 4);
        txn(0, "rd_base2", 32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 4);

        // Backpressure, with a stray request held during RESP that must be ignored.
        rsp_ready[0] = 1'b0;
        issue(0, 32'h8000_0010, 1'b0, 32'h0, 4'h0, lat);
        chk("bp_lat", 32'(lat), 32'd4);
        req_addr[0] = 32'h8000_0000; req_wen[0] = 1'b1;
        req_wdata[0] = 32'h0; req_mask[0] = 4'hF; req_valid[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", {31'b0, rsp_valid[0]}, 32'd1);
            chk("bp_rdata", rsp_rdata[0], 32'hAA22_AA44);
            chk("bp_err", {31'b0, rsp_err[0]}, 32'd0);
            chk("bp_req_ready", {31'b0, req_ready[0]}, 32'd0);
            @(posedge clk); #1;
        end
        req_valid[0] = 1'b0;
        complete(0);
        txn(0, "rd_after_bp", 32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 4);

        // Reset while a write is still waiting: the write must be dropped.
        txn(0, "wr_zero20", 32'h8000_0020, 1'b1, 32'h0, 4'hF, 32'h0, 1'b0, 4);
        txn(0, "rd_nonzero", 32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 4);
        req_addr[0] = 32'h8000_0020; req_wen[0] = 1'b1;
        req_wdata[0] = 32'h9999_9999; req_mask[0] = 4'hF; req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        chk("wait_req_ready", {31'b0, req_ready[0]}, 32'd0);
        rst = 1'b1;
        #1;
        chk("arst_req_ready", {31'b0, req_ready[0]}, 32'd1);
        chk("arst_rsp_valid", {31'b0, rsp_valid[0]}, 32'd0);
        chk("arst_rdata", rsp_rdata[0], 32'd0);
        chk("arst_err", {31'b0, rsp_err[0]}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        txn(0, "rd_dropped", 32'h8000_0020, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 4);

        // Reset after the commit edge: the write must persist.
        issue(0, 32'h8000_0024, 1'b1, 32'h0000_0077, 4'hF, lat);
        rst = 1'b1;
        #1;
        chk("arst2_rsp_valid", {31'b0, rsp_valid[0]}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        txn(0, "rd_committed", 32'h8000_0024, 1'b0, 32'h0, 4'h0, 32'h0000_0077, 1'b0, 4);

        // Random-latency instance: latency = LAT+2+lfsr[1:0], LFSR stepping once per accept.
        lfsr_m = 8'hA5;
        for (int i = 0; i < 16; i++) begin
            sb[i] = 32'h5A00_0000 ^ (32'(i) * 32'h0103_0507);
            txn(1, "rnd_wr", 32'h8000_0000 + 32'(4 * i), 1'b1, sb[i], 4'hF,
                32'h0, 1'b0, 3 + int'(lfsr_m[1:0]));
            lfsr_m = lfsr_step(lfsr_m);
        end
        for (int j = 0; j < 50; j++) begin
            idx = int'($urandom_range(0, 15));
            issue(1, 32'h8000_0000 + 32'(4 * idx), 1'b0, 32'h0, 4'h0, lat);
            chk("rnd_lat_window", {31'b0, (lat >= 3 && lat <= 6)}, 32'd1);
            chk("rnd_lat", 32'(lat), 32'(3 + int'(lfsr_m[1:0])));
            chk("rnd_rdata", rsp_rdata[1], sb[idx]);
            chk("rnd_err", {31'b0, rsp_err[1]}, 32'd0);
            complete(1);
            lfsr_m = lfsr_step(lfsr_m);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
